// File: rtl/fwd_pkg.sv
// Shared types for the operand forwarding unit: stage-entry record, select
// encoding and the select-width helper.
package fwd_pkg;

  // Entries are stored at these widths; instances use the low DATA_W/ADDR_W bits.
  localparam int FWD_MAX_ADDR_W = 8;
  localparam int FWD_MAX_DATA_W = 64;

  localparam int SEL_REGFILE = 0;

  typedef struct packed {
    logic                      valid;
    logic [FWD_MAX_ADDR_W-1:0] addr;
    logic                      ready;
    logic [FWD_MAX_DATA_W-1:0] data;
  } fwd_entry_t;

  function automatic int fwd_sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_lookup.sv
// Single-channel priority match of a source register against the in-flight
// result stages; the youngest matching stage wins.
module fwd_lookup
  import fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2,
  parameter int SEL_W  = fwd_sel_width(DEPTH)
) (
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [DATA_W-1:0] src_data_i,
  input  fwd_entry_t        entries_i [DEPTH],
  output logic [DATA_W-1:0] op_data_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              hazard_o
);

  logic              hit;
  logic              hit_ready;
  logic [DATA_W-1:0] hit_data;
  logic [SEL_W-1:0]  hit_sel;

  always_comb begin
    hit       = 1'b0;
    hit_ready = 1'b0;
    hit_data  = '0;
    hit_sel   = SEL_W'(SEL_REGFILE);
    // Walk oldest to youngest so a younger match overrides an older one.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entries_i[k].valid &&
          entries_i[k].addr == FWD_MAX_ADDR_W'(src_addr_i)) begin
        hit       = 1'b1;
        hit_ready = entries_i[k].ready;
        hit_data  = DATA_W'(entries_i[k].data);
        hit_sel   = SEL_W'(k + 1);
      end
    end
    if (src_addr_i == '0) begin
      hit = 1'b0;
    end
  end

  assign op_data_o = (hit && hit_ready) ? hit_data : src_data_i;
  assign sel_o     = hit ? hit_sel : SEL_W'(SEL_REGFILE);
  assign hazard_o  = hit && !hit_ready;

endmodule

// File: rtl/operand_forward_unit.sv
// Tracks in-flight results across DEPTH stages and forwards them to NUM_SRC
// operand channels, flagging channels whose producer (a load) is not ready yet.
module operand_forward_unit
  import fwd_pkg::*;
#(
  parameter int  DATA_W     = 32,
  parameter int  ADDR_W     = 5,
  parameter int  NUM_SRC    = 2,
  parameter int  DEPTH      = 2,
  parameter int  LOAD_STAGE = 1,
  localparam int SEL_W      = fwd_sel_width(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      advance_i,
  input  logic                      flush_i,
  input  logic                      wb_valid_i,
  input  logic [ADDR_W-1:0]         wb_addr_i,
  input  logic                      wb_ready_i,
  input  logic [DATA_W-1:0]         wb_data_i,
  input  logic                      late_valid_i,
  input  logic [DATA_W-1:0]         late_data_i,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
  output logic [NUM_SRC*DATA_W-1:0] op_data_o,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
  output logic                      hazard_o,
  output logic [15:0]               hazard_cnt_o
);

  fwd_entry_t         stage_q [DEPTH];
  fwd_entry_t         stage_d [DEPTH];
  logic [15:0]        hazard_cnt_q;
  logic [15:0]        hazard_cnt_d;
  logic [NUM_SRC-1:0] ch_hazard;
  int                 late_idx;

  // late_valid_i is a one-cycle strobe with no back-pressure: it is consumed
  // on the edge it is seen, or dropped if its target entry cannot take it.
  always_comb begin
    stage_d  = stage_q;
    late_idx = advance_i ? LOAD_STAGE + 1 : LOAD_STAGE;
    if (advance_i) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        stage_d[k] = stage_q[k-1];
      end
      stage_d[0].valid = wb_valid_i;
      stage_d[0].addr  = FWD_MAX_ADDR_W'(wb_addr_i);
      stage_d[0].ready = wb_ready_i;
      stage_d[0].data  = FWD_MAX_DATA_W'(wb_data_i);
    end
    // The load's entry moves one stage when the pipe advances in the same cycle.
    for (int k = 0; k < DEPTH; k++) begin
      if (late_valid_i && k == late_idx && stage_d[k].valid && !stage_d[k].ready) begin
        stage_d[k].ready = 1'b1;
        stage_d[k].data  = FWD_MAX_DATA_W'(late_data_i);
      end
    end
    if (flush_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_d[k].valid = 1'b0;
      end
    end
  end

  always_comb begin
    hazard_cnt_d = hazard_cnt_q;
    if (hazard_o && hazard_cnt_q != 16'hFFFF) begin
      hazard_cnt_d = hazard_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      hazard_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  for (genvar c = 0; c < NUM_SRC; c++) begin : g_ch
    fwd_lookup #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_lookup (
      .src_addr_i (src_addr_i[c*ADDR_W +: ADDR_W]),
      .src_data_i (src_data_i[c*DATA_W +: DATA_W]),
      .entries_i  (stage_q),
      .op_data_o  (op_data_o[c*DATA_W +: DATA_W]),
      .sel_o      (fwd_sel_o[c*SEL_W +: SEL_W]),
      .hazard_o   (ch_hazard[c])
    );
  end

  assign hazard_o     = |ch_hazard;
  assign hazard_cnt_o = hazard_cnt_q;

endmodule

// File: tb/tb_operand_forward_unit.sv
// Directed bench for operand_forward_unit: a queue-based result-pipeline model
// checked every cycle, plus hand-computed literal expectations.
module tb_operand_forward_unit;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int NUM_SRC    = 2;
  localparam int DEPTH      = 2;
  localparam int LOAD_STAGE = 1;
  localparam int SEL_W      = 2;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic                      advance_i, flush_i;
  logic                      wb_valid_i, wb_ready_i;
  logic [ADDR_W-1:0]         wb_addr_i;
  logic [DATA_W-1:0]         wb_data_i;
  logic                      late_valid_i;
  logic [DATA_W-1:0]         late_data_i;
  logic [NUM_SRC*ADDR_W-1:0] src_addr_i;
  logic [NUM_SRC*DATA_W-1:0] src_data_i;
  logic [NUM_SRC*DATA_W-1:0] op_data_o;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;
  logic                      hazard_o;
  logic [15:0]               hazard_cnt_o;

  operand_forward_unit #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_SRC    (NUM_SRC),
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .advance_i    (advance_i),
    .flush_i      (flush_i),
    .wb_valid_i   (wb_valid_i),
    .wb_addr_i    (wb_addr_i),
    .wb_ready_i   (wb_ready_i),
    .wb_data_i    (wb_data_i),
    .late_valid_i (late_valid_i),
    .late_data_i  (late_data_i),
    .src_addr_i   (src_addr_i),
    .src_data_i   (src_data_i),
    .op_data_o    (op_data_o),
    .fwd_sel_o    (fwd_sel_o),
    .hazard_o     (hazard_o),
    .hazard_cnt_o (hazard_cnt_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    int unsigned a;
    bit          r;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];   // index 0 = youngest result
  int unsigned m_cnt;
  int          m_t;
  bit          m_any_hz;

  function automatic void m_reset();
    ent_t e;
    e.v = 0; e.a = 0; e.r = 0; e.d = '0;
    m_q.delete();
    for (int i = 0; i < DEPTH; i++) m_q.push_back(e);
    m_cnt = 0;
  endfunction

  function automatic void m_lookup(input int unsigned a, input logic [31:0] rf,
                                   output logic [31:0] op, output int sel, output bit hz);
    op = rf; sel = 0; hz = 0;
    if (a == 0) return;
    foreach (m_q[i]) begin
      if (m_q[i].v && m_q[i].a == a) begin
        sel = i + 1;
        if (m_q[i].r) op = m_q[i].d;
        else hz = 1;
        return;
      end
    end
  endfunction

  function automatic bit m_hazard_now();
    logic [31:0] op;
    int sel;
    bit hz, any;
    any = 0;
    for (int c = 0; c < NUM_SRC; c++) begin
      m_lookup(src_addr_i[c*ADDR_W +: ADDR_W], src_data_i[c*DATA_W +: DATA_W], op, sel, hz);
      any |= hz;
    end
    return any;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk_i or negedge rst_i);
      if (!rst_i) begin
        m_reset();
      end else begin
        ent_t e;
        m_any_hz = m_hazard_now();
        if (m_any_hz && m_cnt < 65535) m_cnt++;
        if (flush_i) begin
          foreach (m_q[i]) m_q[i].v = 0;
        end else begin
          if (advance_i) begin
            e.v = wb_valid_i; e.a = wb_addr_i; e.r = wb_ready_i; e.d = wb_data_i;
            m_q.push_front(e);
            void'(m_q.pop_back());
            m_t = LOAD_STAGE + 1;
          end else begin
            m_t = LOAD_STAGE;
          end
          if (late_valid_i && m_t < DEPTH && m_q[m_t].v && !m_q[m_t].r) begin
            m_q[m_t].r = 1;
            m_q[m_t].d = late_data_i;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] op;
    int sel;
    bit hz, any;
    any = 0;
    for (int c = 0; c < NUM_SRC; c++) begin
      m_lookup(src_addr_i[c*ADDR_W +: ADDR_W], src_data_i[c*DATA_W +: DATA_W], op, sel, hz);
      any |= hz;
      cmp($sformatf("model op ch%0d", c), 64'(op_data_o[c*DATA_W +: DATA_W]), 64'(op));
      cmp($sformatf("model sel ch%0d", c), 64'(fwd_sel_o[c*SEL_W +: SEL_W]), 64'(sel));
    end
    cmp("model hazard", 64'(hazard_o), 64'(any));
    cmp("model hazard_cnt", 64'(hazard_cnt_o), 64'(m_cnt));
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      #2 check_model();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    advance_i = 0; flush_i = 0;
    wb_valid_i = 0; wb_addr_i = '0; wb_ready_i = 0; wb_data_i = '0;
    late_valid_i = 0; late_data_i = '0;
  endtask

  task automatic wb(input logic [ADDR_W-1:0] a, input logic rdy, input logic [DATA_W-1:0] d);
    wb_valid_i = 1; wb_addr_i = a; wb_ready_i = rdy; wb_data_i = d; advance_i = 1;
  endtask

  task automatic src(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    src_addr_i[c*ADDR_W +: ADDR_W] = a;
    src_data_i[c*DATA_W +: DATA_W] = d;
  endtask

  function automatic logic [63:0] op_ch(input int c);
    return 64'(op_data_o[c*DATA_W +: DATA_W]);
  endfunction

  function automatic logic [63:0] sel_ch(input int c);
    return 64'(fwd_sel_o[c*SEL_W +: SEL_W]);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    rst_i = 0;
    src_addr_i = '0; src_data_i = '0;
    src(0, 5'd3, 32'h11);
    src(1, 5'd0, 32'h22);
    repeat (2) @(negedge clk_i);
    #3;
    cmp("reset op0", op_ch(0), 64'h11);
    cmp("reset sel0", sel_ch(0), 64'h0);
    cmp("reset hazard", 64'(hazard_o), 64'h0);
    cmp("reset cnt", 64'(hazard_cnt_o), 64'h0);

    @(negedge clk_i); rst_i = 1;
    #3 cmp("post-reset op0", op_ch(0), 64'h11);

    // two ALU writes to r3, the younger one must win
    @(negedge clk_i); wb(5'd3, 1, 32'hAA);
    @(negedge clk_i); wb(5'd3, 1, 32'hBB);
    @(negedge clk_i); idle(); src(1, 5'd3, 32'h22);
    #3;
    cmp("alu op0", op_ch(0), 64'hBB);
    cmp("alu sel0", sel_ch(0), 64'h1);
    cmp("alu op1", op_ch(1), 64'hBB);

    // load r5 not ready, then late data at stage 1
    @(negedge clk_i); wb(5'd5, 0, 32'hDEAD); src(0, 5'd5, 32'h11);
    @(negedge clk_i); idle();
    #3;
    cmp("load hazard", 64'(hazard_o), 64'h1);
    cmp("load sel0", sel_ch(0), 64'h1);
    cmp("load op0", op_ch(0), 64'h11);
    cmp("load sel1 older", sel_ch(1), 64'h2);
    cmp("load cnt0", 64'(hazard_cnt_o), 64'h0);
    @(negedge clk_i);
    #3 cmp("load cnt1", 64'(hazard_cnt_o), 64'h1);
    @(negedge clk_i); advance_i = 1;
    #3 cmp("load cnt2", 64'(hazard_cnt_o), 64'h2);
    @(negedge clk_i); idle(); late_valid_i = 1; late_data_i = 32'h55;
    #3;
    cmp("late sel0 before", sel_ch(0), 64'h2);
    cmp("late cnt3", 64'(hazard_cnt_o), 64'h3);
    @(negedge clk_i); idle();
    #3;
    cmp("late op0", op_ch(0), 64'h55);
    cmp("late hazard", 64'(hazard_o), 64'h0);
    cmp("late cnt4", 64'(hazard_cnt_o), 64'h4);

    // older ready r3 must not be used behind a younger pending r3
    @(negedge clk_i); wb(5'd3, 1, 32'h77);
    @(negedge clk_i); wb(5'd3, 0, 32'h0);
    @(negedge clk_i); idle();
    #3;
    cmp("shadow sel1", sel_ch(1), 64'h1);
    cmp("shadow op1", op_ch(1), 64'h22);
    cmp("shadow hazard", 64'(hazard_o), 64'h1);
    // late data with advance at the last stage is dropped
    @(negedge clk_i); advance_i = 1; late_valid_i = 1; late_data_i = 32'h99;
    @(negedge clk_i); idle();
    #3;
    cmp("drop sel1", sel_ch(1), 64'h2);
    cmp("drop op1", op_ch(1), 64'h22);
    cmp("drop hazard", 64'(hazard_o), 64'h1);

    // r0 never forwards
    @(negedge clk_i); wb(5'd0, 1, 32'hFF); src(0, 5'd0, 32'h0);
    @(negedge clk_i); idle();
    #3;
    cmp("r0 op0", op_ch(0), 64'h0);
    cmp("r0 sel0", sel_ch(0), 64'h0);

    // flush together with advance empties the pipe
    @(negedge clk_i); wb(5'd7, 1, 32'h70); src(0, 5'd7, 32'h1234);
    @(negedge clk_i); wb(5'd7, 1, 32'h71);
    @(negedge clk_i); idle();
    #3;
    cmp("fill sel0", sel_ch(0), 64'h1);
    cmp("fill op0", op_ch(0), 64'h71);
    @(negedge clk_i); wb(5'd7, 1, 32'h72); flush_i = 1;
    @(negedge clk_i); idle();
    #3;
    cmp("flush sel0", sel_ch(0), 64'h0);
    cmp("flush op0", op_ch(0), 64'h1234);

    // long hazard saturates the counter; async reset clears it at once
    @(negedge clk_i); wb(5'd9, 0, 32'h0); src(0, 5'd9, 32'h1234);
    @(negedge clk_i); idle();
    repeat (70000) @(negedge clk_i);
    #3;
    cmp("sat cnt", 64'(hazard_cnt_o), 64'hFFFF);
    cmp("sat hazard", 64'(hazard_o), 64'h1);
    #1 rst_i = 0;
    #1;
    cmp("async rst cnt", 64'(hazard_cnt_o), 64'h0);
    cmp("async rst sel0", sel_ch(0), 64'h0);
    cmp("async rst hazard", 64'(hazard_o), 64'h0);
    cmp("async rst op0", op_ch(0), 64'h1234);
    repeat (2) @(negedge clk_i);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_forward_unit.md
OPERAND_FORWARD_UNIT -- requirements
Module: operand_forward_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: operand/result width.
REQ-002 The block SHALL have parameter ADDR_W, default 5: register address width.
REQ-003 The block SHALL have parameter NUM_SRC, default 2: number of source-operand channels.
REQ-004 The block SHALL have parameter DEPTH, default 2: number of in-flight result stages tracked (>=1).
REQ-005 The block SHALL have parameter LOAD_STAGE, default 1: stage index receiving late (load) data; 0 <= LOAD_STAGE < DEPTH.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port advance_i, input, 1 bit: pipeline advances this cycle.
REQ-009 The block SHALL have port flush_i, input, 1 bit: discard all in-flight entries.
REQ-010 The block SHALL have port wb_valid_i, input, 1 bit: entering instruction writes a register.
REQ-011 The block SHALL have port wb_addr_i, input, ADDR_W bits: entering destination register.
REQ-012 The block SHALL have port wb_ready_i, input, 1 bit: entering result is available now (ALU); 0 means it arrives later (load).
REQ-013 The block SHALL have port wb_data_i, input, DATA_W bits: entering result, meaningful when wb_ready_i=1.
REQ-014 The block SHALL have port late_valid_i, input, 1 bit: late data for the entry at LOAD_STAGE.
REQ-015 The block SHALL have port late_data_i, input, DATA_W bits: late result value.
REQ-016 The block SHALL have port src_addr_i, input, NUM_SRC*ADDR_W bits: source register addresses, channel c at bits [c*ADDR_W +: ADDR_W].
REQ-017 The block SHALL have port src_data_i, input, NUM_SRC*DATA_W bits: register-file read data per channel.
REQ-018 The block SHALL have port op_data_o, output, NUM_SRC*DATA_W bits: forwarded operand per channel.
REQ-019 The block SHALL have port fwd_sel_o, output, NUM_SRC*SEL_W bits: per channel, 0 = register file, k = stage k-1 matched.
REQ-020 The block SHALL have port hazard_o, output, 1 bit: some channel matched an entry whose data is not ready.
REQ-021 The block SHALL have port hazard_cnt_o, output, 16 bits: saturating count of cycles with hazard_o=1.

Function
REQ-022 Each stage entry SHALL hold valid, addr, ready and data; stage 0 is youngest.
REQ-023 When advance_i=1 and flush_i=0, stage k SHALL take stage k-1, stage 0 SHALL take {wb_valid_i, wb_addr_i, wb_ready_i, wb_data_i}, and stage DEPTH-1 SHALL be dropped.
REQ-024 When advance_i=0, entries SHALL hold and wb_* SHALL be ignored.
REQ-025 When flush_i=1, all valid bits SHALL clear at the next edge, regardless of advance_i and late_valid_i.
REQ-026 late_valid_i=1 with advance_i=0 SHALL set ready=1 and data=late_data_i in stage LOAD_STAGE.
REQ-027 late_valid_i=1 with advance_i=1 SHALL write into stage LOAD_STAGE+1 after the shift; if LOAD_STAGE=DEPTH-1, the data SHALL be dropped.
REQ-028 Late data to an entry that is invalid or already ready SHALL be ignored.
REQ-029 Lookup SHALL be combinational (zero latency): per channel, the youngest valid entry with addr equal to the source address SHALL win.
REQ-030 Source address 0 SHALL never match; that channel SHALL output src_data with sel=0.
REQ-031 A channel with a ready match SHALL output the entry's data; with no match it SHALL output src_data with sel=0.
REQ-032 A channel with a not-ready youngest match SHALL output src_data, SHALL report sel of that stage, and SHALL assert hazard_o; an older ready match SHALL NOT be used.
REQ-033 hazard_cnt_o SHALL increment each cycle hazard_o=1 and SHALL saturate at 16'hFFFF.
REQ-034 SEL_W SHALL equal clog2(DEPTH+1).

Reset
REQ-035 While rst_i=0, asynchronously: all entry valid/ready bits=0, data=0, addr=0, hazard_cnt_o=0; consequently op_data_o=src_data_i, fwd_sel_o=0, hazard_o=0.
REQ-036 Reset asserted mid-operation SHALL discard in-flight entries and any pending late data.

Structure
REQ-037 A shared package fwd_pkg SHALL hold the sel-width function, the stage-entry struct, and the constant SEL_REGFILE=0.
REQ-038 Per-channel priority match SHALL be a sub-module fwd_lookup, instantiated NUM_SRC times.

Verification
REQ-039 Reset then src_addr ch0=3, src_data=0x11 SHALL give op=0x11, sel=0, hazard=0.
REQ-040 ALU write r3=0xAA then advance, then write r3=0xBB then advance, then read r3 SHALL give op=0xBB, sel=1.
REQ-041 Load r5 (ready=0) then advance, then read r5 SHALL give hazard=1 and cnt counting; late_valid with 0x55 at stage 1, advance=0 SHALL give op=0x55, hazard=0 next cycle.
REQ-042 Write r0=0xFF then read r0 with src_data=0 SHALL give op=0, sel=0.
REQ-043 Fill stages with r7, then flush_i=1 and advance_i=1 together SHALL give no match next cycle, sel=0.
REQ-044 Hold hazard for 70000 cycles SHALL give hazard_cnt_o=0xFFFF; rst_i low mid-run SHALL clear it immediately.
